paddle_centroid_tracker: RTL and testbench

Per-frame colour-blob tracker that sits upstream of the paddle/ball collision stage. Consumes the camera pixel stream (row, col, RGB), thresholds each pixel against a target colour, accumulates hit count and coordinate sums over one frame, and on each `newFrame` pulse divides them to produce the blob centroid. The collision stage uses the centroid as the paddle centre (`cRow`/`cCol`) in place of button-driven paddles.

---
 rtl/centroid_pkg.sv | 29 ++
 rtl/seq_divider.sv | 70 +++++++
 rtl/paddle_centroid_tracker.sv | 215 +++++++++++++++++++++
 tb/tb_paddle_centroid_tracker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// Shared widths, FSM states, channel encodings and bbox record for the centroid tracker.
package centroid_pkg;
  localparam int CNT_W   = 19;
  localparam int SUM_W   = 32;
  localparam int COORD_W = 13;

  localparam int DIV_CYCLES        = 32;
  localparam logic [4:0] DIV_LAST  = 5'(DIV_CYCLES - 1);

  localparam int unsigned COLOR_R = 0;
  localparam int unsigned COLOR_G = 1;
  localparam int unsigned COLOR_B = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV     = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] bot;
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] right;
  } bbox_t;

  // An empty box has min above max so the first hit overwrites both ends.
  localparam bbox_t BBOX_EMPTY = '{top: '1, bot: '0, left: '1, right: '0};
endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle over DIV_CYCLES cycles; start wins over abort.
module seq_divider
  import centroid_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);
  logic [SUM_W-1:0] dvd_q, dvd_d;
  logic [CNT_W-1:0] dsr_q, dsr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [4:0]       step_q, step_d;
  logic             busy_q, busy_d;
  logic [CNT_W:0]   trial;

  // The dividend register shifts left and collects quotient bits from the bottom.
  always_comb begin
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    rem_d  = rem_q;
    step_d = step_q;
    busy_d = busy_q;
    trial  = {rem_q, dvd_q[SUM_W-1]};
    if (start) begin
      dvd_d  = dividend;
      dsr_d  = divisor;
      rem_d  = '0;
      step_d = '0;
      busy_d = 1'b1;
    end else if (abort) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      if (trial >= {1'b0, dsr_q}) begin
        rem_d = CNT_W'(trial - {1'b0, dsr_q});
        dvd_d = {dvd_q[SUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[CNT_W-1:0];
        dvd_d = {dvd_q[SUM_W-2:0], 1'b0};
      end
      step_d = step_q + 5'd1;
      if (step_q == DIV_LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      rem_q  <= rem_d;
      step_q <= step_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (step_q == DIV_LAST);
  assign quotient = dvd_q;
endmodule

// File: rtl/paddle_centroid_tracker.sv
// Per-frame colour-blob centroid: threshold, accumulate, divide on newFrame, publish 33 cycles later.
// Define CENTROID_BBOX_EN to also track and publish the blob bounding box.
module paddle_centroid_tracker
  import centroid_pkg::*;
#(
  parameter logic [COORD_W-1:0] ROWS       = 13'd640,
  parameter logic [COORD_W-1:0] COLS       = 13'd480,
  parameter int unsigned        COLOR_SEL  = COLOR_R,
  parameter logic [7:0]         THRESH     = 8'd64,
  parameter logic [CNT_W-1:0]   MIN_PIXELS = 19'd64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               newFrame,
  input  logic               pixValid,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic [7:0]         pixR,
  input  logic [7:0]         pixG,
  input  logic [7:0]         pixB,
  output logic [COORD_W-1:0] cRow,
  output logic [COORD_W-1:0] cCol,
  output logic               found,
  output logic               centroidValid,
  output logic [CNT_W-1:0]   hitCount,
  output logic               overrun,
  output logic [COORD_W-1:0] bboxTop,
  output logic [COORD_W-1:0] bboxBot,
  output logic [COORD_W-1:0] bboxLeft,
  output logic [COORD_W-1:0] bboxRight
);
  logic [7:0]         tgt, oth1, oth2;
  logic               pix_hit;
  logic               s1_hit_q, s1_hit_d;
  logic [COORD_W-1:0] s1_row_q, s1_row_d, s1_col_q, s1_col_d;
  logic [CNT_W-1:0]   count_q, count_d, snap_cnt_q, snap_cnt_d, hit_count_q, hit_count_d;
  logic [SUM_W-1:0]   sum_row_q, sum_row_d, sum_col_q, sum_col_d;
  state_e             state_q, state_d;
  logic [4:0]         cyc_q, cyc_d;
  logic               skip_q, skip_d, overrun_q, overrun_d;
  logic               cvalid_q, cvalid_d, found_q, found_d;
  logic [COORD_W-1:0] crow_q, crow_d, ccol_q, ccol_d;
  logic               publish, frame_found, div_start;
  logic               row_busy, row_done, col_busy, col_done;
  logic [SUM_W-1:0]   row_quot, col_quot;
  logic               unused_div;

  always_comb begin
    tgt  = pixR;
    oth1 = pixG;
    oth2 = pixB;
    case (COLOR_SEL)
      COLOR_G: begin tgt = pixG; oth1 = pixR; oth2 = pixB; end
      COLOR_B: begin tgt = pixB; oth1 = pixR; oth2 = pixG; end
      default: ;
    endcase
    pix_hit = pixValid && (row < ROWS) && (col < COLS)
           && ({1'b0, tgt} > ({1'b0, oth1} + {1'b0, THRESH}))
           && ({1'b0, tgt} > ({1'b0, oth2} + {1'b0, THRESH}));
  end

  assign frame_found = (snap_cnt_q >= MIN_PIXELS);
  assign div_start   = newFrame && (count_q != '0);

  always_comb begin
    s1_hit_d = pix_hit;
    s1_row_d = row;
    s1_col_d = col;
    // A hit arriving on the snapshot edge belongs to the frame that is just starting.
    count_d   = (newFrame ? '0 : count_q) + CNT_W'(s1_hit_q);
    sum_row_d = (newFrame ? '0 : sum_row_q) + (s1_hit_q ? SUM_W'(s1_row_q) : '0);
    sum_col_d = (newFrame ? '0 : sum_col_q) + (s1_hit_q ? SUM_W'(s1_col_q) : '0);

    state_d    = state_q;
    cyc_d      = cyc_q;
    snap_cnt_d = snap_cnt_q;
    skip_d     = skip_q;
    overrun_d  = overrun_q;
    publish    = 1'b0;
    if (newFrame) begin
      state_d    = DIV;
      cyc_d      = '0;
      snap_cnt_d = count_q;
      skip_d     = (count_q == '0);
      if (state_q != IDLE) overrun_d = 1'b1;
    end else begin
      case (state_q)
        DIV: begin
          cyc_d = cyc_q + 5'd1;
          if (skip_q ? (cyc_q == DIV_LAST) : (row_done && col_done)) state_d = PUBLISH;
        end
        PUBLISH: begin
          state_d = IDLE;
          publish = 1'b1;
        end
        default: ;
      endcase
    end

    cvalid_d    = publish;
    hit_count_d = hit_count_q;
    found_d     = found_q;
    crow_d      = crow_q;
    ccol_d      = ccol_q;
    if (publish) begin
      hit_count_d = snap_cnt_q;
      found_d     = frame_found;
      if (frame_found) begin
        crow_d = skip_q ? '0 : row_quot[COORD_W-1:0];
        ccol_d = skip_q ? '0 : col_quot[COORD_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_hit_q    <= 1'b0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      count_q     <= '0;
      sum_row_q   <= '0;
      sum_col_q   <= '0;
      state_q     <= IDLE;
      cyc_q       <= '0;
      snap_cnt_q  <= '0;
      skip_q      <= 1'b0;
      overrun_q   <= 1'b0;
      cvalid_q    <= 1'b0;
      hit_count_q <= '0;
      found_q     <= 1'b0;
      crow_q      <= ROWS >> 1;
      ccol_q      <= COLS >> 1;
    end else begin
      s1_hit_q    <= s1_hit_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      count_q     <= count_d;
      sum_row_q   <= sum_row_d;
      sum_col_q   <= sum_col_d;
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      snap_cnt_q  <= snap_cnt_d;
      skip_q      <= skip_d;
      overrun_q   <= overrun_d;
      cvalid_q    <= cvalid_d;
      hit_count_q <= hit_count_d;
      found_q     <= found_d;
      crow_q      <= crow_d;
      ccol_q      <= ccol_d;
    end
  end

  seq_divider u_row_div (
    .clk(clk), .reset(reset), .start(div_start), .abort(newFrame),
    .dividend(sum_row_q), .divisor(count_q),
    .busy(row_busy), .done(row_done), .quotient(row_quot)
  );

  seq_divider u_col_div (
    .clk(clk), .reset(reset), .start(div_start), .abort(newFrame),
    .dividend(sum_col_q), .divisor(count_q),
    .busy(col_busy), .done(col_done), .quotient(col_quot)
  );

  // Only the coordinate-sized low quotient bits are meaningful for an in-region blob.
  assign unused_div = ^{row_quot[SUM_W-1:COORD_W], col_quot[SUM_W-1:COORD_W], row_busy, col_busy};

`ifdef CENTROID_BBOX_EN
  bbox_t frame_bb_q, frame_bb_d, snap_bb_q, snap_bb_d, out_bb_q, out_bb_d;
  bbox_t base_bb;

  always_comb begin
    base_bb    = newFrame ? BBOX_EMPTY : frame_bb_q;
    frame_bb_d = base_bb;
    if (s1_hit_q) begin
      if (s1_row_q < base_bb.top)   frame_bb_d.top   = s1_row_q;
      if (s1_row_q > base_bb.bot)   frame_bb_d.bot   = s1_row_q;
      if (s1_col_q < base_bb.left)  frame_bb_d.left  = s1_col_q;
      if (s1_col_q > base_bb.right) frame_bb_d.right = s1_col_q;
    end
    snap_bb_d = newFrame ? frame_bb_q : snap_bb_q;
    out_bb_d  = out_bb_q;
    if (publish && frame_found && (snap_cnt_q != '0)) out_bb_d = snap_bb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_bb_q <= BBOX_EMPTY;
      snap_bb_q  <= BBOX_EMPTY;
      out_bb_q   <= '0;
    end else begin
      frame_bb_q <= frame_bb_d;
      snap_bb_q  <= snap_bb_d;
      out_bb_q   <= out_bb_d;
    end
  end

  assign bboxTop   = out_bb_q.top;
  assign bboxBot   = out_bb_q.bot;
  assign bboxLeft  = out_bb_q.left;
  assign bboxRight = out_bb_q.right;
`else
  assign bboxTop   = '0;
  assign bboxBot   = '0;
  assign bboxLeft  = '0;
  assign bboxRight = '0;
`endif

  assign cRow          = crow_q;
  assign cCol          = ccol_q;
  assign found         = found_q;
  assign centroidValid = cvalid_q;
  assign hitCount      = hit_count_q;
  assign overrun       = overrun_q;
endmodule

// File: tb/tb_paddle_centroid_tracker.sv
// Randomized frame-level bench for paddle_centroid_tracker against a per-frame arithmetic model.
module tb_paddle_centroid_tracker;
  logic        clk = 1'b0;
  logic        reset, newFrame, pixValid;
  logic [12:0] row, col;
  logic [7:0]  pixR, pixG, pixB;
  logic [12:0] cRow, cCol, bboxTop, bboxBot, bboxLeft, bboxRight;
  logic        found, centroidValid, overrun;
  logic [18:0] hitCount;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int r; int c; int cr; int cg; int cb; } pix_t;
  pix_t frame_q[$];
  pix_t inject_q[$];

  int exp_crow = 320, exp_ccol = 240, exp_hits = 0;
  int exp_found = 0, exp_overrun = 0;
  int exp_bt = 0, exp_bb = 0, exp_bl = 0, exp_br = 0;

  paddle_centroid_tracker #(.THRESH(8'd110)) dut (
    .clk(clk), .reset(reset), .newFrame(newFrame), .pixValid(pixValid),
    .row(row), .col(col), .pixR(pixR), .pixG(pixG), .pixB(pixB),
    .cRow(cRow), .cCol(cCol), .found(found), .centroidValid(centroidValid),
    .hitCount(hitCount), .overrun(overrun),
    .bboxTop(bboxTop), .bboxBot(bboxBot), .bboxLeft(bboxLeft), .bboxRight(bboxRight)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pix_t mk(int r, int c, int cr, int cg, int cb);
    pix_t p;
    p.r = r; p.c = c; p.cr = cr; p.cg = cg; p.cb = cb;
    return p;
  endfunction

  function automatic bit is_hit(pix_t p);
    return (p.r < 640) && (p.c < 480) && (p.cr > p.cg + 110) && (p.cr > p.cb + 110);
  endfunction

  task automatic drive_pix(input pix_t p);
    pixValid = 1'b1;
    row  = 13'(p.r);
    col  = 13'(p.c);
    pixR = 8'(p.cr);
    pixG = 8'(p.cg);
    pixB = 8'(p.cb);
    frame_q.push_back(p);
    tick();
  endtask

  task automatic idle(input int n);
    pixValid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse();
    pixValid = 1'b0;
    newFrame = 1'b1;
    tick();
    newFrame = 1'b0;
  endtask

  function automatic pix_t rand_pix();
    if ($urandom_range(0, 1) == 1)
      return mk($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(140, 255),
                $urandom_range(0, 80), $urandom_range(0, 80));
    return mk($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255));
  endfunction

  // Reference result of one frame: plain totals and floor means over every hit pixel.
  task automatic model_frame();
    int cnt, t, b, l, rt;
    longint sr, sc;
    cnt = 0; sr = 0; sc = 0; t = 8191; b = 0; l = 8191; rt = 0;
    foreach (frame_q[i]) begin
      if (is_hit(frame_q[i])) begin
        cnt++;
        sr += frame_q[i].r;
        sc += frame_q[i].c;
        if (frame_q[i].r < t)  t  = frame_q[i].r;
        if (frame_q[i].r > b)  b  = frame_q[i].r;
        if (frame_q[i].c < l)  l  = frame_q[i].c;
        if (frame_q[i].c > rt) rt = frame_q[i].c;
      end
    end
    exp_hits  = cnt;
    exp_found = (cnt >= 64) ? 1 : 0;
    if (exp_found == 1) begin
      exp_crow = int'(sr / cnt);
      exp_ccol = int'(sc / cnt);
`ifdef CENTROID_BBOX_EN
      exp_bt = t; exp_bb = b; exp_bl = l; exp_br = rt;
`endif
    end
    frame_q.delete();
  endtask

  task automatic test_frame(input string name, input int nblank);
    int lat;
    lat = 0;
    idle(nblank);
    pulse();
    model_frame();
    while (lat < 60) begin
      if (inject_q.size() > 0) drive_pix(inject_q.pop_front());
      else idle(1);
      lat++;
      if (centroidValid === 1'b1) break;
    end
    pixValid = 1'b0;
    inject_q.delete();
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL %s latency got %0d want 33", name, lat); end
    n_cmp++; if (hitCount !== 19'(exp_hits)) begin n_bad++; $display("FAIL %s hitCount got %0d want %0d", name, hitCount, exp_hits); end
    n_cmp++; if (found !== 1'(exp_found)) begin n_bad++; $display("FAIL %s found got %0d want %0d", name, found, exp_found); end
    n_cmp++; if (cRow !== 13'(exp_crow)) begin n_bad++; $display("FAIL %s cRow got %0d want %0d", name, cRow, exp_crow); end
    n_cmp++; if (cCol !== 13'(exp_ccol)) begin n_bad++; $display("FAIL %s cCol got %0d want %0d", name, cCol, exp_ccol); end
    n_cmp++; if (overrun !== 1'(exp_overrun)) begin n_bad++; $display("FAIL %s overrun got %0d want %0d", name, overrun, exp_overrun); end
    n_cmp++;
    if ({bboxTop, bboxBot, bboxLeft, bboxRight} !== {13'(exp_bt), 13'(exp_bb), 13'(exp_bl), 13'(exp_br)}) begin
      n_bad++;
      $display("FAIL %s bbox got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", name, bboxTop, bboxBot,
               bboxLeft, bboxRight, exp_bt, exp_bb, exp_bl, exp_br);
    end
    idle(1);
    n_cmp++; if (centroidValid !== 1'b0) begin n_bad++; $display("FAIL %s pulse_width centroidValid got %0d want 0", name, centroidValid); end
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++; if (cRow !== 13'd320) begin n_bad++; $display("FAIL %s cRow got %0d want 320", name, cRow); end
    n_cmp++; if (cCol !== 13'd240) begin n_bad++; $display("FAIL %s cCol got %0d want 240", name, cCol); end
    n_cmp++; if (found !== 1'b0) begin n_bad++; $display("FAIL %s found got %0d want 0", name, found); end
    n_cmp++; if (centroidValid !== 1'b0) begin n_bad++; $display("FAIL %s centroidValid got %0d want 0", name, centroidValid); end
    n_cmp++; if (hitCount !== 19'd0) begin n_bad++; $display("FAIL %s hitCount got %0d want 0", name, hitCount); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL %s overrun got %0d want 0", name, overrun); end
    n_cmp++;
    if ({bboxTop, bboxBot, bboxLeft, bboxRight} !== 52'd0) begin
      n_bad++;
      $display("FAIL %s bbox got %0d/%0d/%0d/%0d want 0/0/0/0", name, bboxTop, bboxBot, bboxLeft, bboxRight);
    end
  endtask

  task automatic send_block(input int r0, input int c0);
    for (int r = r0 - 2; r < r0 + 12; r++)
      for (int c = c0 - 2; c < c0 + 12; c++)
        if (r >= r0 && r < r0 + 10 && c >= c0 && c < c0 + 10) drive_pix(mk(r, c, 255, 0, 0));
        else drive_pix(mk(r, c, 0, 0, 0));
  endtask

  task automatic test_reset();
    reset = 1'b1; newFrame = 1'b0; pixValid = 1'b0;
    row = '0; col = '0; pixR = '0; pixG = '0; pixB = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_values("reset");
  endtask

  task automatic test_block();
    send_block(100, 200);
    test_frame("block", 3);
    n_cmp++; if (hitCount !== 19'd100) begin n_bad++; $display("FAIL block_const hitCount got %0d want 100", hitCount); end
    n_cmp++; if ({cRow, cCol} !== {13'd104, 13'd204}) begin n_bad++; $display("FAIL block_const centroid got %0d/%0d want 104/204", cRow, cCol); end
`ifdef CENTROID_BBOX_EN
    n_cmp++;
    if ({bboxTop, bboxBot, bboxLeft, bboxRight} !== {13'd100, 13'd109, 13'd200, 13'd209}) begin
      n_bad++;
      $display("FAIL block_bbox got %0d/%0d/%0d/%0d want 100/109/200/209", bboxTop, bboxBot, bboxLeft, bboxRight);
    end
`endif
  endtask

  task automatic test_few_hits();
    for (int i = 0; i < 8; i++) drive_pix(mk(10 + i, 20 + i, 255, 0, 0));
    test_frame("few_hits", 3);
    n_cmp++; if ({found, cRow, cCol} !== {1'b0, 13'd104, 13'd204}) begin n_bad++; $display("FAIL few_hold got %0d %0d/%0d want 0 104/204", found, cRow, cCol); end
  endtask

  task automatic test_threshold();
    for (int i = 0; i < 80; i++) drive_pix(mk(i, i, 200, 90, 90));
    test_frame("thresh_equal", 3);
    n_cmp++; if (hitCount !== 19'd0) begin n_bad++; $display("FAIL thresh_equal_const hitCount got %0d want 0", hitCount); end
    for (int i = 0; i < 80; i++) drive_pix(mk(i, 2 * i, 200, 89, 89));
    test_frame("thresh_above", 3);
    n_cmp++; if (hitCount !== 19'd80) begin n_bad++; $display("FAIL thresh_above_const hitCount got %0d want 80", hitCount); end
    for (int i = 0; i < 50; i++) drive_pix(mk(i, i, 0, 0, 0));
    test_frame("black", 3);
  endtask

  task automatic test_out_of_region();
    for (int r = 700; r < 710; r++)
      for (int c = 500; c < 510; c++) drive_pix(mk(r, c, 255, 0, 0));
    drive_pix(mk(640, 10, 255, 0, 0));
    drive_pix(mk(10, 480, 255, 0, 0));
    test_frame("out_of_region", 3);
    n_cmp++; if (hitCount !== 19'd0) begin n_bad++; $display("FAIL oor_const hitCount got %0d want 0", hitCount); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(60, 160);
      for (int i = 0; i < n; i++) drive_pix(rand_pix());
      // Pixels fed while the previous result is still being divided.
      for (int i = 0; i < 20; i++) inject_q.push_back(rand_pix());
      test_frame("random", 3);
    end
  endtask

  task automatic test_overrun();
    send_block(300, 100);
    idle(3);
    pulse();
    frame_q.delete();
    for (int i = 1; i <= 7; i++) begin
      drive_pix(mk(400 + i, 100, 255, 0, 0));
      n_cmp++; if (centroidValid !== 1'b0) begin n_bad++; $display("FAIL overrun_early centroidValid got %0d want 0", centroidValid); end
    end
    exp_overrun = 1;
    test_frame("overrun", 2);
  endtask

  task automatic test_reset_mid_div();
    int seen;
    send_block(100, 200);
    idle(3);
    pulse();
    frame_q.delete();
    for (int i = 1; i <= 14; i++) begin
      if (i <= 10) drive_pix(mk(500, i, 255, 0, 0));
      else idle(1);
    end
    reset = 1'b1;
    pixValid = 1'b0;
    tick();
    reset = 1'b0;
    check_reset_values("reset_mid");
    exp_crow = 320; exp_ccol = 240; exp_hits = 0; exp_found = 0; exp_overrun = 0;
    exp_bt = 0; exp_bb = 0; exp_bl = 0; exp_br = 0;
    frame_q.delete();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (centroidValid === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL reset_mid_nopulse pulses got %0d want 0", seen); end
    send_block(100, 200);
    test_frame("after_reset", 3);
    n_cmp++; if (hitCount !== 19'd100) begin n_bad++; $display("FAIL after_reset_const hitCount got %0d want 100", hitCount); end
  endtask

  initial begin
    test_reset();
    test_block();
    test_few_hits();
    test_threshold();
    test_out_of_region();
    test_random();
    test_overrun();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
